// File: rtl/noise_burst_if.sv
// Control and sample bus of the white-noise voice sequencer.
// The master side drives strobes and burst settings; the slave side returns samples.
interface noise_burst_if #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned LEN_W = 16
);
  logic             i_sample_tick;
  logic             i_trig;
  logic [DIV_W-1:0] i_period;
  logic [LEN_W-1:0] i_length;
  logic [7:0]       i_decay;
  logic [15:0]      o_data;
  logic             o_valid;
  logic             o_busy;

  modport master (
    output i_sample_tick, i_trig, i_period, i_length, i_decay,
    input  o_data, o_valid, o_busy
  );

  modport slave (
    input  i_sample_tick, i_trig, i_period, i_length, i_decay,
    output o_data, o_valid, o_busy
  );
endinterface

// File: rtl/noise_burst_ctrl.sv
// White-noise voice sequencer: 16-bit LFSR stepped at a programmable tick rate,
// gated by a trigger-started HOLD/DECAY gain envelope, one sample per tick.
module noise_burst_ctrl #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned LEN_W = 16,
  parameter logic [15:0] SEED  = 16'hDEAD
) (
  input  logic            i_clk,
  input  logic            i_rst,
  noise_burst_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, HOLD, DECAY} state_t;

  state_t           state;
  logic [0:15]      lfsr;
  logic [7:0]       gain;
  logic [DIV_W-1:0] div_cnt;
  logic [LEN_W-1:0] hold_cnt;
  logic [7:0]       dec_cnt;
  logic [DIV_W-1:0] period_l;
  logic [7:0]       decay_l;

  logic [15:0]        w_adj;
  logic signed [23:0] prod;
  logic [DIV_W-1:0]   period_m1;
  logic               dec_due;

  // r[0] is the word MSB; -32768 is nudged to -32767 so the output stays symmetric.
  // |w*gain| <= 32767*255 fits in 24 signed bits, so bits [23:8] equal the shifted product.
  always_comb begin
    w_adj     = (lfsr == 16'h8000) ? 16'h8001 : lfsr;
    prod      = $signed(w_adj) * $signed({1'b0, gain});
    period_m1 = (period_l == '0) ? '0 : period_l - DIV_W'(1);
    dec_due   = (decay_l == 8'd0) || (dec_cnt >= decay_l - 8'd1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      lfsr        <= SEED;
      gain        <= '0;
      div_cnt     <= '0;
      hold_cnt    <= '0;
      dec_cnt     <= '0;
      period_l    <= '0;
      decay_l     <= '0;
      bus.o_data  <= '0;
      bus.o_valid <= 1'b0;
      bus.o_busy  <= 1'b0;
    end else begin
      bus.o_valid <= bus.i_sample_tick;
      if (bus.i_sample_tick)
        bus.o_data <= (state == IDLE) ? '0 : prod[23:8];

      if (bus.i_trig) begin
        period_l   <= bus.i_period;
        decay_l    <= bus.i_decay;
        hold_cnt   <= bus.i_length;
        gain       <= 8'd255;
        dec_cnt    <= '0;
        div_cnt    <= '0;
        state      <= HOLD;
        bus.o_busy <= 1'b1;
      end else if (state != IDLE && bus.i_sample_tick) begin
        if (div_cnt == period_m1) begin
          lfsr    <= {lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3], lfsr[0:14]};
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end

        case (state)
          HOLD: begin
            if (hold_cnt == '0) state <= DECAY;
            else                hold_cnt <= hold_cnt - LEN_W'(1);
          end
          DECAY: begin
            if (dec_due) begin
              gain    <= gain - 8'd1;
              dec_cnt <= '0;
              if (gain == 8'd1) begin
                state      <= IDLE;
                bus.o_busy <= 1'b0;
              end
            end else begin
              dec_cnt <= dec_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
